// File: rtl/peak_window_detector.sv
// peak_window_detector: signed extremum detector for the averaged OPO sweep
// stream. It tracks the running max/min (and their window-relative indices)
// over a software-armed window of valid samples. Results are published once
// per completed window.

package opo_package;
  localparam int word_width = 16;
endpackage

module peak_window_detector
  import opo_package::*;
#(
  parameter int IDX_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [IDX_WIDTH-1:0]  window_len,
  input  logic [word_width-1:0] sample_in,
  input  logic                  sample_in_valid,
  output logic [word_width-1:0] max_value,
  output logic [IDX_WIDTH-1:0]  max_index,
  output logic [word_width-1:0] min_value,
  output logic [IDX_WIDTH-1:0]  min_index,
  output logic                  result_valid,
  output logic                  busy
);

  localparam logic IDLE = 1'b0;
  localparam logic SCAN = 1'b1;

  logic                         state;
  logic [IDX_WIDTH-1:0]         len_r;
  logic [IDX_WIDTH-1:0]         cnt;
  logic signed [word_width-1:0] run_max;
  logic signed [word_width-1:0] run_min;
  logic [IDX_WIDTH-1:0]         run_max_idx;
  logic [IDX_WIDTH-1:0]         run_min_idx;

  logic signed [word_width-1:0] sample_s;
  logic signed [word_width-1:0] next_max;
  logic signed [word_width-1:0] next_min;
  logic [IDX_WIDTH-1:0]         next_max_idx;
  logic [IDX_WIDTH-1:0]         next_min_idx;
  logic                         last_sample;

  assign sample_s    = signed'(sample_in);
  assign last_sample = (cnt == (len_r - IDX_WIDTH'(1)));
  assign busy        = (state == SCAN);

  // Running extrema including the current sample; strict compares keep the earliest index on ties.
  always_comb begin
    next_max     = run_max;
    next_min     = run_min;
    next_max_idx = run_max_idx;
    next_min_idx = run_min_idx;
    if (cnt == '0) begin
      next_max     = sample_s;
      next_min     = sample_s;
      next_max_idx = '0;
      next_min_idx = '0;
    end else begin
      if (sample_s > run_max) begin
        next_max     = sample_s;
        next_max_idx = cnt;
      end
      if (sample_s < run_min) begin
        next_min     = sample_s;
        next_min_idx = cnt;
      end
    end
  end

  // FSM, window counter, running registers and published results; abort overrides everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      len_r        <= '0;
      cnt          <= '0;
      run_max      <= '0;
      run_min      <= '0;
      run_max_idx  <= '0;
      run_min_idx  <= '0;
      max_value    <= '0;
      max_index    <= '0;
      min_value    <= '0;
      min_index    <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start && (window_len != '0)) begin
              state <= SCAN;
              len_r <= window_len;
              cnt   <= '0;
            end
          end
          SCAN: begin
            if (sample_in_valid) begin
              run_max     <= next_max;
              run_min     <= next_min;
              run_max_idx <= next_max_idx;
              run_min_idx <= next_min_idx;
              if (last_sample) begin
                max_value    <= next_max;
                max_index    <= next_max_idx;
                min_value    <= next_min;
                min_index    <= next_min_idx;
                result_valid <= 1'b1;
                state        <= IDLE;
              end else begin
                cnt <= cnt + IDX_WIDTH'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_peak_window_detector.sv
// tb_peak_window_detector: table-driven windows plus hand-written sequences
// for gaps, aborts, degenerate lengths, back-to-back windows and reset.

module tb_peak_window_detector;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] window_len;
  logic [15:0] sample_in;
  logic        sample_in_valid;
  logic [15:0] max_value;
  logic [15:0] max_index;
  logic [15:0] min_value;
  logic [15:0] min_index;
  logic        result_valid;
  logic        busy;

  int n_vectors = 0;
  int n_miscompares = 0;

  typedef struct {
    logic [15:0]       len;
    int                n;
    logic [7:0][15:0]  s;
    logic [15:0]       max_v;
    logic [15:0]       max_i;
    logic [15:0]       min_v;
    logic [15:0]       min_i;
  } vec_t;

  vec_t vecs [5];

  peak_window_detector #(.IDX_WIDTH(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .window_len      (window_len),
    .sample_in       (sample_in),
    .sample_in_valid (sample_in_valid),
    .max_value       (max_value),
    .max_index       (max_index),
    .min_value       (min_value),
    .min_index       (min_index),
    .result_valid    (result_valid),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge before driving/checking.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_results(input string tag, input logic [15:0] mv, input logic [15:0] mi,
                               input logic [15:0] nv, input logic [15:0] ni);
    check_output({tag, ".max_value"}, 32'(max_value), 32'(mv));
    check_output({tag, ".max_index"}, 32'(max_index), 32'(mi));
    check_output({tag, ".min_value"}, 32'(min_value), 32'(nv));
    check_output({tag, ".min_index"}, 32'(min_index), 32'(ni));
  endtask

  // Arm a window then feed n back-to-back valid samples; leaves inputs idle.
  task automatic apply_stimulus(input logic [15:0] len, input int n, input logic [7:0][15:0] s);
    start      = 1'b1;
    window_len = len;
    tick();
    start = 1'b0;
    check_output("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      sample_in       = s[i];
      sample_in_valid = 1'b1;
      tick();
      if (i < n - 1) check_output("rv_early", 32'(result_valid), 32'd0);
    end
    sample_in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    window_len = '0; sample_in = '0; sample_in_valid = 1'b0;

    vecs[0].len = 16'd5; vecs[0].n = 5; vecs[0].s = '0;
    vecs[0].s[0] = 16'd10; vecs[0].s[1] = 16'hFFFD; vecs[0].s[2] = 16'd42;
    vecs[0].s[3] = 16'd7;  vecs[0].s[4] = 16'hFFEC;
    vecs[0].max_v = 16'd42; vecs[0].max_i = 16'd2; vecs[0].min_v = 16'hFFEC; vecs[0].min_i = 16'd4;

    vecs[1].len = 16'd4; vecs[1].n = 4; vecs[1].s = '0;
    vecs[1].s[0] = 16'h7FFF; vecs[1].s[1] = 16'h8000; vecs[1].s[2] = 16'h7FFF; vecs[1].s[3] = 16'h8000;
    vecs[1].max_v = 16'h7FFF; vecs[1].max_i = 16'd0; vecs[1].min_v = 16'h8000; vecs[1].min_i = 16'd1;

    vecs[2].len = 16'd1; vecs[2].n = 1; vecs[2].s = '0;
    vecs[2].s[0] = 16'hFFF9;
    vecs[2].max_v = 16'hFFF9; vecs[2].max_i = 16'd0; vecs[2].min_v = 16'hFFF9; vecs[2].min_i = 16'd0;

    vecs[3].len = 16'd3; vecs[3].n = 3; vecs[3].s = '0;
    vecs[3].s[0] = 16'd5; vecs[3].s[1] = 16'd5; vecs[3].s[2] = 16'd5;
    vecs[3].max_v = 16'd5; vecs[3].max_i = 16'd0; vecs[3].min_v = 16'd5; vecs[3].min_i = 16'd0;

    vecs[4].len = 16'd6; vecs[4].n = 6; vecs[4].s = '0;
    vecs[4].s[0] = 16'hFFFF; vecs[4].s[1] = 16'hFFFE; vecs[4].s[2] = 16'd3;
    vecs[4].s[3] = 16'd3;    vecs[4].s[4] = 16'hFFFE; vecs[4].s[5] = 16'd0;
    vecs[4].max_v = 16'd3; vecs[4].max_i = 16'd2; vecs[4].min_v = 16'hFFFE; vecs[4].min_i = 16'd1;

    // Reset state
    #12;
    check_output("reset.busy", 32'(busy), 32'd0);
    check_output("reset.result_valid", 32'(result_valid), 32'd0);
    check_results("reset", 16'd0, 16'd0, 16'd0, 16'd0);
    rst = 1'b1;
    tick();

    // Table-driven windows
    foreach (vecs[k]) begin
      apply_stimulus(vecs[k].len, vecs[k].n, vecs[k].s);
      check_output($sformatf("vec%0d.result_valid", k), 32'(result_valid), 32'd1);
      check_output($sformatf("vec%0d.busy_done", k), 32'(busy), 32'd0);
      check_results($sformatf("vec%0d", k), vecs[k].max_v, vecs[k].max_i, vecs[k].min_v, vecs[k].min_i);
      tick();
      check_output($sformatf("vec%0d.rv_one_cycle", k), 32'(result_valid), 32'd0);
      tick();
    end

    // Gapped valid: len 3, samples 4, -9, 1 with idle cycles between
    start = 1'b1; window_len = 16'd3; tick(); start = 1'b0;
    sample_in = 16'd4; sample_in_valid = 1'b1; tick(); sample_in_valid = 1'b0; tick();
    sample_in = 16'hFFF7; sample_in_valid = 1'b1; tick(); sample_in_valid = 1'b0; tick(); tick();
    check_output("gap.busy_mid", 32'(busy), 32'd1);
    check_output("gap.rv_mid", 32'(result_valid), 32'd0);
    sample_in = 16'd1; sample_in_valid = 1'b1; tick(); sample_in_valid = 1'b0;
    check_output("gap.result_valid", 32'(result_valid), 32'd1);
    check_results("gap", 16'd4, 16'd0, 16'hFFF7, 16'd1);
    tick();

    // Abort after two samples: no result, outputs hold
    start = 1'b1; window_len = 16'd3; tick(); start = 1'b0;
    sample_in = 16'd100; sample_in_valid = 1'b1; tick();
    sample_in = 16'hFF9C; tick();
    sample_in_valid = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
    check_output("abort.busy", 32'(busy), 32'd0);
    sample_in = 16'd50; sample_in_valid = 1'b1; tick(); sample_in_valid = 1'b0;
    check_output("abort.rv", 32'(result_valid), 32'd0);
    tick();
    check_output("abort.rv_late", 32'(result_valid), 32'd0);
    check_results("abort_hold", 16'd4, 16'd0, 16'hFFF7, 16'd1);

    // Abort coincident with completing sample wins
    start = 1'b1; window_len = 16'd2; tick(); start = 1'b0;
    sample_in = 16'd1; sample_in_valid = 1'b1; tick();
    sample_in = 16'd2; abort = 1'b1; tick(); abort = 1'b0; sample_in_valid = 1'b0;
    check_output("abort_last.rv", 32'(result_valid), 32'd0);
    check_output("abort_last.busy", 32'(busy), 32'd0);
    check_results("abort_last", 16'd4, 16'd0, 16'hFFF7, 16'd1);

    // Abort and start together in IDLE: stay IDLE
    start = 1'b1; abort = 1'b1; window_len = 16'd3; tick(); start = 1'b0; abort = 1'b0;
    check_output("abort_start.busy", 32'(busy), 32'd0);

    // window_len = 0 is ignored
    start = 1'b1; window_len = 16'd0; tick(); start = 1'b0;
    check_output("len0.busy", 32'(busy), 32'd0);
    sample_in = 16'd9; sample_in_valid = 1'b1; tick(); sample_in_valid = 1'b0;
    check_output("len0.rv", 32'(result_valid), 32'd0);

    // Sample with accepted start not counted; start during SCAN ignored
    start = 1'b1; window_len = 16'd2; sample_in = 16'd1000; sample_in_valid = 1'b1; tick();
    start = 1'b0; sample_in = 16'd8; tick();
    start = 1'b1; window_len = 16'd5; sample_in = 16'd9; tick();
    start = 1'b0; sample_in_valid = 1'b0;
    check_output("scan_start.result_valid", 32'(result_valid), 32'd1);
    check_results("scan_start", 16'd9, 16'd1, 16'd8, 16'd0);
    tick();
    check_output("scan_start.busy_after", 32'(busy), 32'd0);

    // Back-to-back windows with continuous valid
    start = 1'b1; window_len = 16'd2; sample_in = 16'h0100; sample_in_valid = 1'b1; tick();
    start = 1'b0; sample_in = 16'd3; tick();
    sample_in = 16'hFFFC; tick();
    check_output("b2b_1.result_valid", 32'(result_valid), 32'd1);
    check_results("b2b_1", 16'd3, 16'd0, 16'hFFFC, 16'd1);
    start = 1'b1; window_len = 16'd2; sample_in = 16'd77; tick();
    start = 1'b0;
    check_output("b2b_2.busy", 32'(busy), 32'd1);
    check_output("b2b_2.rv_low", 32'(result_valid), 32'd0);
    sample_in = 16'hFFFB; tick();
    sample_in = 16'd6; tick();
    sample_in_valid = 1'b0;
    check_output("b2b_2.result_valid", 32'(result_valid), 32'd1);
    check_results("b2b_2", 16'd6, 16'd1, 16'hFFFB, 16'd0);
    tick();

    // Reset asserted mid-scan clears everything immediately
    start = 1'b1; window_len = 16'd4; tick(); start = 1'b0;
    sample_in = 16'd20; sample_in_valid = 1'b1; tick(); tick();
    #2 rst = 1'b0;
    #1;
    check_output("rst_mid.busy", 32'(busy), 32'd0);
    check_output("rst_mid.result_valid", 32'(result_valid), 32'd0);
    check_results("rst_mid", 16'd0, 16'd0, 16'd0, 16'd0);
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    sample_in_valid = 1'b0;
    check_output("rst_after.rv", 32'(result_valid), 32'd0);
    check_output("rst_after.busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/peak_window_detector.md
# peak_window_detector

Signed extremum detector that sits directly downstream of the two-sample moving-average stage in the OPO locking path. It consumes the averaged sample stream over a software-armed window of N valid samples and reports the maximum and minimum values plus the window-relative index of each. The lock controller uses these results to locate the resonance peak during a cavity sweep.

## Interface
- Parameter `IDX_WIDTH`, default 16: width of the window length and of the index outputs.
- `word_width` is the opo_package constant and is not a parameter of this block.
- Ports (reset is rst, asynchronous, active-low; clock is clk):
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle arm request; sampled only in IDLE
- `abort`  in  1  cancels the scan in progress; has priority over all other inputs
- `window_len`  in  IDX_WIDTH  number of valid samples per window; latched on accepted start
- `sample_in`  in  word_width  signed two's-complement sample from the averager
- `sample_in_valid`  in  1  sample qualifier, one-cycle pulses from the averager
- `max_value`  out  word_width  largest sample of the last completed window
- `max_index`  out  IDX_WIDTH  index (0-based, counted in valid samples) of max_value
- `min_value`  out  word_width  smallest sample of the last completed window
- `min_index`  out  IDX_WIDTH  index of min_value
- `result_valid`  out  1  one-cycle pulse when new results are presented
- `busy`  out  1  high while in SCAN

## Operation
- FSM states: IDLE, SCAN.
- IDLE -> SCAN on `start`=1 with `window_len`≠0:
  - latch window_len into len_r;
  - clear sample counter cnt to 0;
  - `busy` rises next cycle.
- `start` with `window_len`=0 is ignored; the FSM stays in IDLE.
- `start` asserted while in SCAN is ignored. It does not restart the scan or reload len_r.
- SCAN, on each `sample_in_valid`:
  - at cnt=0: load run_max=run_min=sample_in, run_max_idx=run_min_idx=0;
  - at cnt>0: compare signed;
  - if sample_in > run_max (strict), update run_max and run_max_idx=cnt;
  - if sample_in < run_min (strict), update run_min and run_min_idx=cnt;
  - ties keep the earliest index;
  - then cnt increments.
- Window completion is the valid sample with cnt = len_r−1. On that edge:
  - the four outputs load the final running values, including that sample's own comparison;
  - `result_valid` goes high;
  - the FSM returns to IDLE.
- Outputs change only at window completion. They hold the last result through later scans, aborts and idle time.
- `abort`=1 in any state: return to IDLE, no `result_valid`, outputs unchanged, running registers don't care.
- `sample_in_valid` in IDLE is ignored.
- Comparisons are full-width signed: 0x8000 is less than 0x7FFF for word_width=16.
- Internal cnt is IDX_WIDTH wide. It never wraps, because completion occurs at len_r−1 ≤ 2^IDX_WIDTH−2.

## Timing
- Reset values: all outputs 0, FSM IDLE, internal registers 0.
- Reset mid-scan returns everything to the reset values immediately (asynchronous).
- start to busy: 1 cycle.
- First valid sample may arrive in the same cycle busy rises, or later. A sample coincident with the accepted `start` is not counted.
- Last valid sample to result_valid/outputs: 1 cycle. Registered on the completing edge, visible the following cycle for exactly one cycle.
- busy falls in the same cycle result_valid is high.
- A new `start` is accepted in the cycle result_valid is high. Back-to-back windows lose no samples after the start edge.
- Simultaneous `abort` and completing sample: abort wins, no result.
- Simultaneous `abort` and `start` in IDLE: abort wins, remain IDLE.
- Throughput: one sample per cycle; `sample_in_valid` may be continuously high.

## Test plan
- Reset check: rst low mid-scan -> all outputs 0, busy 0, no result_valid.
- Basic window:
  - stimulus: window_len=5, samples 10, −3, 42, 7, −20;
  - response: max_value=42 / max_index=2, min_value=−20 / min_index=4;
  - result_valid pulses 1 cycle after the 5th valid sample.
- Ties and sign boundary:
  - stimulus: window_len=4, samples 0x7FFF, 0x8000, 0x7FFF, 0x8000 (16-bit);
  - response: max index 0, min index 1, min_value=0x8000.
- Gapped valid and abort:
  - a window_len=3 scan with idle cycles between samples completes normally;
  - a second scan aborted after 2 samples -> no result_valid, outputs keep the first scan's results.
- Degenerate lengths:
  - window_len=0 start -> busy stays 0;
  - window_len=1 with sample −7 -> max=min=−7, both indices 0.
- Back-to-back:
  - stimulus: continuous valid; start reasserted in the result_valid cycle, window_len=2;
  - response: second window covers the samples following the new start edge and reports correct extrema.
